// File: rtl/mlaccel_memory_pkg.sv
// Shared constants, FSM state type and lane-rotation helper for the banked accelerator memory.
// Latency: none (package only).
// Backpressure: not applicable.
package mlaccel_memory_pkg;

  // Width of one lane / one physical SPRAM bank word.
  localparam int LANE_W = 16;
  // Byte write enables per lane.
  localparam int MASK_W = 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // Left rotation by 'shift' lanes: output lane 'lane' takes input lane lane_rot(lane, shift, nlanes).
  // nlanes must be a power of two; shift may range 0..nlanes.
  function automatic int unsigned lane_rot(input int unsigned lane,
                                           input int unsigned shift,
                                           input int unsigned nlanes);
    return (lane + nlanes - shift) & (nlanes - 1);
  endfunction

endpackage

// File: rtl/mlaccel_memory_bank.sv
// One 16-bit single-port RAM bank with byte write enables; RADIANT or ICE40 selects the hard SPRAM.
// Latency: read data registered, valid the cycle after the address is presented.
// Backpressure: none; accepts an access every cycle.
module mlaccel_memory_bank
  import mlaccel_memory_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic              clock,
  input  logic [AW-1:0]     addr,
  input  logic [MASK_W-1:0] wen,
  input  logic [LANE_W-1:0] wdata,
  output logic [LANE_W-1:0] rdata
);

`ifdef RADIANT
  // Nexus/Radiant SPRAM: nibble mask, so each byte enable drives two mask bits.
  SP256K u_spram (
    .AD      (addr),
    .DI      (wdata),
    .MASKWE  ({wen[1], wen[1], wen[0], wen[0]}),
    .WE      (|wen),
    .CS      (1'b1),
    .CK      (clock),
    .STDBY   (1'b0),
    .SLEEP   (1'b0),
    .PWROFF_N(1'b1),
    .DO      (rdata)
  );
`elsif ICE40
  // iCE40UP SPRAM: same nibble-mask arrangement as the Radiant primitive.
  SB_SPRAM256KA u_spram (
    .ADDRESS   (addr),
    .DATAIN    (wdata),
    .MASKWREN  ({wen[1], wen[1], wen[0], wen[0]}),
    .WREN      (|wen),
    .CHIPSELECT(1'b1),
    .CLOCK     (clock),
    .STANDBY   (1'b0),
    .SLEEP     (1'b0),
    .POWEROFF  (1'b1),
    .DATAOUT   (rdata)
  );
`else
  logic [LANE_W-1:0] mem [2**AW];
  logic [LANE_W-1:0] rdata_q;

  // Byte-masked write plus registered read; contents are never reset.
  always_ff @(posedge clock) begin
    if (wen[0]) mem[addr][7:0]  <= wdata[7:0];
    if (wen[1]) mem[addr][15:8] <= wdata[15:8];
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;
`endif

endmodule

// File: rtl/mlaccel_memory_banked.sv
// Unaligned multi-lane SPRAM memory with burst reads/fills; MLACCEL_MEMORY_STATS_EN enables beat counters.
// Latency: read data returns exactly 2 cycles after its beat is issued (bank read + rotate register).
// Backpressure: req_ready drops for the tail of a burst; responses cannot be stalled by the consumer.
module mlaccel_memory_banked
  import mlaccel_memory_pkg::*;
#(
  parameter  int NBANKS  = 4,
  parameter  int BANK_AW = 14,
  parameter  int LEN_W   = 8,
  localparam int SW      = $clog2(NBANKS),
  localparam int ADDR_W  = BANK_AW + $clog2(NBANKS),
  localparam int DW      = LANE_W * NBANKS,
  localparam int MW      = MASK_W * NBANKS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [MW-1:0]     req_wen,
  input  logic [DW-1:0]     req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  output logic [DW-1:0]     rsp_data,
  output logic              rsp_last,
  output logic              busy,
  output logic [31:0]       stat_rd,
  output logic [31:0]       stat_wr
);

  // Burst engine state.
  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [MW-1:0]      wen_q, wen_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;

  // Beat being issued to the banks this cycle.
  logic               issue;
  logic               iss_last;
  logic [ADDR_W-1:0]  iss_addr;
  logic [MW-1:0]      iss_wen;
  logic [DW-1:0]      iss_wdata;
  logic               rd_issue;

  // Read pipeline: stage 1 waits on the bank, stage 2 is the output register.
  logic               v1_q, v1_d;
  logic               last1_q, last1_d;
  logic [SW-1:0]      s1_q, s1_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_last_q, rsp_last_d;
  logic [DW-1:0]      rsp_data_q, rsp_data_d;

  // Lane/bank routing.
  logic [SW-1:0]      iss_s;
  logic [BANK_AW-1:0] iss_base;
  logic [BANK_AW-1:0] iss_base_p1;
  logic [LANE_W-1:0]  wlane      [NBANKS];
  logic [MASK_W-1:0]  mlane      [NBANKS];
  logic [BANK_AW-1:0] bank_addr  [NBANKS];
  logic [MASK_W-1:0]  bank_wen   [NBANKS];
  logic [LANE_W-1:0]  bank_wdata [NBANKS];
  logic [LANE_W-1:0]  bank_rdata [NBANKS];
  logic [DW-1:0]      rd_rot;

  // Pick the beat source (live request or latched burst) and compute the next burst state.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wen_d     = wen_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    issue     = 1'b0;
    iss_last  = 1'b1;
    iss_addr  = req_addr;
    iss_wen   = req_wen;
    iss_wdata = req_wdata;
    case (state_q)
      ST_IDLE: begin
        issue    = req_valid;
        iss_last = (req_len == '0);
        if (req_valid && (req_len != '0)) begin
          state_d = ST_BURST;
          addr_d  = req_addr + ADDR_W'(NBANKS);
          wen_d   = req_wen;
          wdata_d = req_wdata;
          cnt_d   = req_len;
        end
      end
      default: begin
        issue     = 1'b1;
        iss_addr  = addr_q;
        iss_wen   = wen_q;
        iss_wdata = wdata_q;
        iss_last  = (cnt_q == LEN_W'(1));
        addr_d    = addr_q + ADDR_W'(NBANKS);
        cnt_d     = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) state_d = ST_IDLE;
      end
    endcase
  end

  assign rd_issue = issue && (iss_wen == '0);

  // Burst engine registers; reset abandons any burst in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wen_q   <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Split the request word into lanes for rotation.
  for (genvar i = 0; i < NBANKS; i++) begin : g_lane
    assign wlane[i] = iss_wdata[i*LANE_W +: LANE_W];
    assign mlane[i] = iss_wen[i*MASK_W +: MASK_W];
  end

  // Banks below the start lane hold the wrapped part of the word, one row further on.
  always_comb begin
    iss_s       = iss_addr[SW-1:0];
    iss_base    = iss_addr[ADDR_W-1:SW];
    iss_base_p1 = iss_base + BANK_AW'(1);
    for (int unsigned b = 0; b < NBANKS; b++) begin
      bank_addr[b]  = (b < 32'(iss_s)) ? iss_base_p1 : iss_base;
      bank_wdata[b] = wlane[SW'(lane_rot(b, 32'(iss_s), NBANKS))];
      bank_wen[b]   = issue ? mlane[SW'(lane_rot(b, 32'(iss_s), NBANKS))] : '0;
    end
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    mlaccel_memory_bank #(
      .AW(BANK_AW)
    ) u_bank (
      .clock(clock),
      .addr (bank_addr[b]),
      .wen  (bank_wen[b]),
      .wdata(bank_wdata[b]),
      .rdata(bank_rdata[b])
    );
  end

  // Undo the write rotation using the start lane captured alongside the read.
  always_comb begin
    rd_rot = '0;
    for (int unsigned i = 0; i < NBANKS; i++) begin
      rd_rot[i*LANE_W +: LANE_W] = bank_rdata[SW'(lane_rot(i, NBANKS - 32'(s1_q), NBANKS))];
    end
  end

  // Response pipeline next-state; data holds its last value between beats.
  always_comb begin
    v1_d        = rd_issue;
    last1_d     = iss_last;
    s1_d        = iss_addr[SW-1:0];
    rsp_valid_d = v1_q;
    rsp_last_d  = v1_q && last1_q;
    rsp_data_d  = v1_q ? rd_rot : rsp_data_q;
  end

  // Response pipeline registers; reset drops reads still in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      s1_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      v1_q        <= v1_d;
      last1_q     <= last1_d;
      s1_q        <= s1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_BURST) || v1_q || rsp_valid_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_data  = rsp_data_q;

`ifdef MLACCEL_MEMORY_STATS_EN
  logic        wr_issue;
  logic [31:0] stat_rd_q, stat_rd_d;
  logic [31:0] stat_wr_q, stat_wr_d;

  assign wr_issue = issue && (iss_wen != '0);

  // Saturating beat counters.
  always_comb begin
    stat_rd_d = stat_rd_q;
    stat_wr_d = stat_wr_q;
    if (rd_issue && (stat_rd_q != '1)) stat_rd_d = stat_rd_q + 32'd1;
    if (wr_issue && (stat_wr_q != '1)) stat_wr_d = stat_wr_q + 32'd1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_rd_q <= '0;
      stat_wr_q <= '0;
    end else begin
      stat_rd_q <= stat_rd_d;
      stat_wr_q <= stat_wr_d;
    end
  end

  assign stat_rd = stat_rd_q;
  assign stat_wr = stat_wr_q;
`else
  assign stat_rd = '0;
  assign stat_wr = '0;
`endif

endmodule

// File: tb/tb_mlaccel_memory_banked.sv
// Randomized bench for mlaccel_memory_banked against a lane-addressed memory model with timed responses.
// Latency: expects each read beat's response exactly 2 cycles after the beat's issue cycle.
// Backpressure: requests are held until req_ready; responses are always sunk.
module tb_mlaccel_memory_banked;

  localparam int NB = 4;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic [7:0]  req_wen;
  logic [63:0] req_wdata;
  logic [7:0]  req_len;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        rsp_last;
  logic        busy;
  logic [31:0] stat_rd;
  logic [31:0] stat_wr;

  mlaccel_memory_banked dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_wen  (req_wen),
    .req_wdata(req_wdata),
    .req_len  (req_len),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_last (rsp_last),
    .busy     (busy),
    .stat_rd  (stat_rd),
    .stat_wr  (stat_wr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference model: one 16-bit entry per lane address plus per-byte "written" flags.
  bit [15:0] mem_m   [65536];
  bit [1:0]  known_m [65536];

  typedef struct {
    int          due;
    logic [63:0] data;
    logic [63:0] mask;
    bit          last;
  } exp_t;

  exp_t q[$];
  int   b_start = 1;
  int   b_end   = 0;
  int   n_rd    = 0;
  int   n_wr    = 0;
  bit   mon_en  = 1'b0;

  // Apply one accepted request (issue cycle c0) to the model.
  function automatic void model_issue(input int c0, input logic [15:0] a, input logic [7:0] w,
                                      input logic [63:0] d, input logic [7:0] l);
    for (int k = 0; k <= int'(l); k++) begin
      logic [15:0] la;
      la = a + 16'(k * NB);
      if (w == 8'h00) begin
        exp_t e;
        e.due  = c0 + k + 2;
        e.last = (k == int'(l));
        e.data = '0;
        e.mask = '0;
        for (int i = 0; i < NB; i++) begin
          logic [15:0] x;
          x = la + 16'(i);
          e.data[i*16 +: 16]  = mem_m[x];
          e.mask[i*16 +: 8]   = {8{known_m[x][0]}};
          e.mask[i*16+8 +: 8] = {8{known_m[x][1]}};
        end
        q.push_back(e);
        n_rd++;
      end else begin
        for (int i = 0; i < NB; i++) begin
          logic [15:0] x;
          x = la + 16'(i);
          for (int j = 0; j < 2; j++) begin
            if (w[2*i+j]) begin
              mem_m[x][8*j +: 8] = d[16*i+8*j +: 8];
              known_m[x][j]      = 1'b1;
            end
          end
        end
        n_wr++;
      end
    end
    if (l != 8'd0) begin
      b_start = c0 + 1;
      b_end   = c0 + int'(l);
    end
  endfunction

  // Per-cycle checks of handshake, busy and the response channel.
  always @(negedge clock) begin
    if (mon_en) begin
      bit in_burst;
      bit exp_busy;
      in_burst = (cyc >= b_start) && (cyc <= b_end);
      exp_busy = in_burst || ((q.size() > 0) && (q[0].due - 1 <= cyc));
      chk("req_ready", 64'(req_ready), 64'(!in_burst));
      chk("busy", 64'(busy), 64'(exp_busy));
      if ((q.size() > 0) && (q[0].due == cyc)) begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rsp_data", rsp_data & e.mask, e.data & e.mask);
        chk("rsp_last", 64'(rsp_last), 64'(e.last));
      end else begin
        chk("rsp_valid_idle", 64'(rsp_valid), 64'd0);
      end
    end
  end

  // Present a request, hold it until accepted, record it in the model.
  task automatic send(input logic [15:0] a, input logic [7:0] w, input logic [63:0] d, input logic [7:0] l);
    int waited;
    waited    = 0;
    req_addr  = a;
    req_wen   = w;
    req_wdata = d;
    req_len   = l;
    req_valid = 1'b1;
    @(negedge clock);
    while (!req_ready && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    if (!req_ready) begin
      chk("req_accept_timeout", 64'(req_ready), 64'd1);
    end else begin
      model_issue(cyc, a, w, d, l);
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  // One-cycle synchronous reset starting in the current cycle.
  task automatic do_reset();
    exp_t keep[$];
    reset = 1'b1;
    keep  = {};
    foreach (q[i]) if (q[i].due <= cyc) keep.push_back(q[i]);
    q = keep;
    if (b_end > cyc) b_end = cyc;
    n_rd = 0;
    n_wr = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || cyc <= b_end) && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    repeat (2) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_wen   = '0;
    req_wdata = '0;
    req_len   = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_last", 64'(rsp_last), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stat_rd", 64'(stat_rd), 64'd0);
    chk("rst_stat_wr", 64'(stat_wr), 64'd0);
    @(posedge clock);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // Aligned-ish write then immediate read of the same word.
    send(16'h0001, 8'hFF, 64'h4444_3333_2222_1111, 8'd0);
    send(16'h0001, 8'h00, 64'd0, 8'd0);
    // Unaligned write crossing the top row, read back at lane address 0.
    send(16'hFFFE, 8'hFF, 64'h4444_3333_2222_1111, 8'd0);
    send(16'h0000, 8'h00, 64'd0, 8'd0);
    // Fill 16 words with zero, then burst-read them.
    send(16'h0000, 8'hFF, 64'd0, 8'd15);
    send(16'h0000, 8'h00, 64'd0, 8'd15);
    // Byte-masked write over a preloaded word.
    send(16'h0100, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'd0);
    send(16'h0100, 8'h01, 64'h0000_0000_0000_00AB, 8'd0);
    send(16'h0100, 8'h00, 64'd0, 8'd0);
    drain();

    // Reset during a read burst.
    send(16'h0010, 8'h00, 64'd0, 8'd7);
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    do_reset();
    @(negedge clock);
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    @(posedge clock);
    #1;

    // Random traffic in two address windows, including the wrap at the top.
    for (int t = 0; t < 300; t++) begin
      logic [15:0] a;
      logic [7:0]  w;
      logic [63:0] d;
      logic [7:0]  l;
      int          gap;
      a   = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 63)) : 16'(16'hFFC0 + 16'($urandom_range(0, 63)));
      w   = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      d   = {$urandom, $urandom};
      l   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 6)) : 8'd0;
      gap = $urandom_range(0, 2);
      send(a, w, d, l);
      repeat (gap) begin
        @(posedge clock);
        #1;
      end
    end
    drain();

    // Beat counters: 3 single writes + 5-beat read after a clean reset.
    do_reset();
    send(16'h0020, 8'hFF, 64'h0123_4567_89AB_CDEF, 8'd0);
    send(16'h0003, 8'h0F, 64'h5555_6666_7777_8888, 8'd0);
    send(16'hFFFD, 8'hF0, 64'h9999_AAAA_BBBB_CCCC, 8'd0);
    send(16'h0000, 8'h00, 64'd0, 8'd4);
    drain();
`ifdef MLACCEL_MEMORY_STATS_EN
    chk("stat_wr", 64'(stat_wr), 64'(n_wr));
    chk("stat_rd", 64'(stat_rd), 64'(n_rd));
`else
    chk("stat_wr_off", 64'(stat_wr), 64'd0);
    chk("stat_rd_off", 64'(stat_rd), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mlaccel_memory_banked.md
Name: mlaccel_memory_banked

Overview:
Parametrised successor to the accelerator's unaligned 4-lane SPRAM memory. It adds a configurable lane count, a valid/ready request handshake and a registered response channel. A burst engine auto-increments the address for multi-word reads and repeated-word fills (memory clearing). Sits between the sequencer/host bus and the physical SPRAM banks; one request port, one response port.

Parameters:
NBANKS, 4, number of 16-bit lanes/banks; power of two, 2..8
BANK_AW, 14, address width of each bank (depth 2**BANK_AW)
LEN_W, 8, width of burst-length field
ADDR_W, BANK_AW+log2(NBANKS), lane-granular address width (derived, not overridable)

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid&&req_ready
req_addr  in  ADDR_W  lane address of lane 0 of the word; any alignment
req_wen  in  2*NBANKS  byte write enables (2 per lane); all zero = read
req_wdata  in  16*NBANKS  write data, lane 0 in LSBs
req_len  in  LEN_W  beats minus one (0 = single beat)
rsp_valid  out  1  read data valid (one cycle per read beat)
rsp_data  out  16*NBANKS  read data, lane 0 in LSBs
rsp_last  out  1  final beat of a read burst
busy  out  1  burst in progress or reads in flight
stat_rd  out  32  read beats counter (see Optional Feature)
stat_wr  out  32  write beats counter (see Optional Feature)

Behaviour:
- Clock port clock; reset synchronous active-high. Outputs after reset: req_ready=1, rsp_valid=0, rsp_last=0, rsp_data=0, busy=0, stat_*=0.
- Lane mapping: s = addr mod NBANKS, base = addr div NBANKS. Bank b receives row base+1 if b<s, else base. Write data/enables rotated left by s lanes. Read data rotated back by the registered s.
- Row wrap: base+1 at row 2**BANK_AW-1 wraps to row 0. Lane-address arithmetic wraps modulo 2**ADDR_W.
- FSM IDLE/BURST. IDLE: req_ready=1. On accept with req_len=0: one beat issued this cycle; stay IDLE. On accept with req_len>0: issue beat 0, latch addr/wen/wdata, cnt=req_len, go BURST.
- BURST: req_ready=0. Each cycle issue one beat at addr += NBANKS; cnt decrements. When the issued beat has cnt==1, return to IDLE. No bubble: a new request is acceptable the cycle after.
- Write burst = fill: the same latched wdata/wen is written to req_len+1 consecutive words.
- Read latency: exactly 2 cycles from beat issue (SPRAM 1 + rotate register) to rsp_valid. No response backpressure: the consumer must sink every beat.
- rsp_last=1 with the final beat of a read burst and with every single-beat read. Writes produce no response.
- busy=1 while in BURST or while any read beat is in the 2-stage pipeline.
- Read immediately following a write to the same word returns the new data.
- Reset mid-burst: FSM to IDLE, pipeline valids cleared, no rsp_valid after reset. Memory contents undefined-but-retained; no clearing.

Optional Feature:
MLACCEL_MEMORY_STATS_EN: defined -> stat_rd/stat_wr count issued read/write beats (including each burst beat), saturate at 2**32-1, cleared by reset. Undefined -> both ports tied to 0, no counter logic.

Decomposition:
- Package mlaccel_memory_pkg: lane width constant (16), mask-bits-per-lane (2), FSM state enum, a rotate helper function.
- One sub-module mlaccel_memory_bank: single 16-bit SPRAM bank (addr, 2-bit wen, wdata, rdata). Instantiated NBANKS times via generate, with RADIANT/iCE40 primitive selection inside.

Test Plan:
- NBANKS=4: write addr=0x0001, wen=0xFF, wdata=0x4444_3333_2222_1111; read addr=0x0001 -> rsp_valid 2 cycles after issue, rsp_data=0x4444_3333_2222_1111, rsp_last=1.
- Unaligned row wrap: write addr=0xFFFE (base row 0x3FFF, s=2), then read lane addr 0x0000 -> lanes 0,1 hold data lanes 2,3 (0x4444_3333 in low 32 bits).
- Fill: addr=0x0000, len=15, wdata=0, wen=0xFF -> req_ready low 15 cycles. Then read burst len=15 -> 16 beats all zero, rsp_last only on beat 16.
- Byte mask: write wen=0x01, wdata=0xAB to a word preloaded 0xFFFF.. -> read returns low byte 0xAB, other bytes 0xFF.
- Reset asserted on cycle 3 of read burst len=7 -> no rsp_valid after reset, req_ready=1, busy=0 next cycle.
- STATS_EN: 3 single writes + read burst len=4 -> stat_wr=3, stat_rd=5; without macro both read 0.
